// File: rtl/bp_fe_pkg.sv
// Front-end realigner package.
//   bp_params_e              - processor configuration selector; proc params derive from it
//   bp_vaddr_width()         - virtual address (PC) width for a configuration
//   bp_instr_width_gp        - fetch word / instruction width
//   bp_fe_realigner_state_e  - realigner FSM states
//   bp_fe_is_compressed()    - 16-bit parcel classification
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_bp_inv_cfg,
        e_bp_default_cfg
    } bp_params_e;

    localparam int unsigned bp_instr_width_gp = 32;

    function automatic int unsigned bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    typedef enum logic [1:0] {
        e_empty,
        e_word,
        e_partial,
        e_straddle
    } bp_fe_realigner_state_e;

    // Any encoding whose low two bits are 11 is treated as a 32-bit instruction.
    function automatic logic bp_fe_is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/bp_fe_realigner.sv
// Front-end parcel realigner: splits 32-bit fetch words into 16-bit compressed parcels and
// 32-bit instructions (including ones straddling two fetch words), one per handshake.
// Ports:
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   flush_i        synchronous discard of all buffered state
//   fetch_v_i      fetch word valid
//   fetch_pc_i     PC of fetch_instr_i; bit1=1 starts at the upper parcel
//   fetch_instr_i  raw fetch word, little-endian parcels
//   fetch_ready_o  word accepted when fetch_v_i & fetch_ready_o
//   v_o            instruction valid
//   instr_o        instruction, or {16'b0, parcel} when compressed
//   pc_o           PC of the instruction's first parcel
//   compressed_o   instr_o holds a 16-bit parcel
//   yumi_i         consumer takes the output (only while v_o=1)
module bp_fe_realigner
    import bp_fe_pkg::*;
#(
    parameter bp_params_e cfg_p = e_bp_default_cfg,
    localparam int unsigned vaddr_width_p = bp_vaddr_width(cfg_p),
    localparam int unsigned instr_width_p = bp_instr_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [instr_width_p-1:0] fetch_instr_i,
    output logic                     fetch_ready_o,
    output logic                     v_o,
    output logic [instr_width_p-1:0] instr_o,
    output logic [vaddr_width_p-1:0] pc_o,
    output logic                     compressed_o,
    input  logic                     yumi_i
);

    localparam logic [vaddr_width_p-1:0] parcel_bytes = vaddr_width_p'(2);

    bp_fe_realigner_state_e state_r, state_n;

    logic [instr_width_p-1:0] word_r, word_n;
    logic [vaddr_width_p-1:0] word_pc_r, word_pc_n;
    logic                     cursor_r, cursor_n;
    logic [15:0]              partial_r, partial_n;
    logic [vaddr_width_p-1:0] partial_pc_r, partial_pc_n;

    logic [15:0]              cur_parcel;
    logic [vaddr_width_p-1:0] cur_pc;
    logic                     cur_compressed;
    logic [vaddr_width_p-1:0] fetch_word_pc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_empty;
            word_r       <= '0;
            word_pc_r    <= '0;
            cursor_r     <= 1'b0;
            partial_r    <= '0;
            partial_pc_r <= '0;
        end else begin
            state_r      <= state_n;
            word_r       <= word_n;
            word_pc_r    <= word_pc_n;
            cursor_r     <= cursor_n;
            partial_r    <= partial_n;
            partial_pc_r <= partial_pc_n;
        end
    end

    always_comb begin
        // Data and PC of the parcel the cursor points at.
        cur_parcel     = cursor_r ? word_r[31:16] : word_r[15:0];
        cur_pc         = cursor_r ? (word_pc_r + parcel_bytes) : word_pc_r;
        cur_compressed = bp_fe_is_compressed(cur_parcel);
        fetch_word_pc  = {fetch_pc_i[vaddr_width_p-1:2], 1'b0, fetch_pc_i[0]};

        state_n      = state_r;
        word_n       = word_r;
        word_pc_n    = word_pc_r;
        cursor_n     = cursor_r;
        partial_n    = partial_r;
        partial_pc_n = partial_pc_r;

        v_o           = 1'b0;
        instr_o       = '0;
        pc_o          = '0;
        compressed_o  = 1'b0;
        fetch_ready_o = ~reset_i & ((state_r == e_empty) | (state_r == e_partial));

        unique case (state_r)
            e_empty: begin
                if (fetch_v_i) begin
                    state_n   = e_word;
                    word_n    = fetch_instr_i;
                    word_pc_n = fetch_word_pc;
                    cursor_n  = fetch_pc_i[1];
                end
            end

            e_word: begin
                if (cur_compressed) begin
                    v_o          = 1'b1;
                    instr_o      = {16'b0, cur_parcel};
                    pc_o         = cur_pc;
                    compressed_o = 1'b1;
                    if (yumi_i) begin
                        if (cursor_r) begin
                            state_n = e_empty;
                        end else begin
                            cursor_n = 1'b1;
                        end
                    end
                end else if (!cursor_r) begin
                    v_o     = 1'b1;
                    instr_o = word_r;
                    pc_o    = word_pc_r;
                    if (yumi_i) begin
                        state_n = e_empty;
                    end
                end else begin
                    // Upper parcel opens a 32-bit instruction: park it and wait for the
                    // next word; no output this cycle.
                    state_n      = e_partial;
                    partial_n    = cur_parcel;
                    partial_pc_n = cur_pc;
                end
            end

            e_partial: begin
                // The incoming word is taken as the successor; its pc bit1 is ignored.
                if (fetch_v_i) begin
                    state_n   = e_straddle;
                    word_n    = fetch_instr_i;
                    word_pc_n = fetch_word_pc;
                end
            end

            e_straddle: begin
                v_o     = 1'b1;
                instr_o = {word_r[15:0], partial_r};
                pc_o    = partial_pc_r;
                if (yumi_i) begin
                    state_n  = e_word;
                    cursor_n = 1'b1;
                end
            end

            default: state_n = e_empty;
        endcase

        // Flush overrides every event decoded above, including an accept or yumi.
        if (flush_i) begin
            state_n      = e_empty;
            word_n       = word_r;
            word_pc_n    = word_pc_r;
            cursor_n     = cursor_r;
            partial_n    = '0;
            partial_pc_n = '0;
        end
    end

endmodule

// File: tb/tb_bp_fe_realigner.sv
module tb_bp_fe_realigner;
    import bp_fe_pkg::*;

    localparam int unsigned VW = bp_vaddr_width(e_bp_default_cfg);

    logic          clk;
    logic          reset;
    logic          flush;
    logic          fetch_v;
    logic [VW-1:0] fetch_pc;
    logic [31:0]   fetch_instr;
    logic          fetch_ready;
    logic          v;
    logic [31:0]   instr;
    logic [VW-1:0] pc;
    logic          compressed;
    logic          yumi;

    int n_cmp;
    int n_bad;

    bp_fe_realigner dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .flush_i       (flush),
        .fetch_v_i     (fetch_v),
        .fetch_pc_i    (fetch_pc),
        .fetch_instr_i (fetch_instr),
        .fetch_ready_o (fetch_ready),
        .v_o           (v),
        .instr_o       (instr),
        .pc_o          (pc),
        .compressed_o  (compressed),
        .yumi_i        (yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          fv;
        logic [VW-1:0] fpc;
        logic [31:0]   fw;
        logic          y;
        logic          fl;
        logic          ev;
        logic [31:0]   ei;
        logic [VW-1:0] ep;
        logic          ec;
        logic          er;
    } vec_t;

    vec_t vecs[$];

    localparam logic [VW-1:0] PC0 = VW'(64'h8000_0000);

    function automatic vec_t mk(input string name, input logic fv, input logic [VW-1:0] fpc,
                                input logic [31:0] fw, input logic y, input logic fl,
                                input logic ev, input logic [31:0] ei, input logic [VW-1:0] ep,
                                input logic ec, input logic er);
        vec_t t;
        t.name = name; t.fv = fv; t.fpc = fpc; t.fw = fw; t.y = y; t.fl = fl;
        t.ev = ev; t.ei = ei; t.ep = ep; t.ec = ec; t.er = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic [31:0] ei,
                              input logic [VW-1:0] ep, input logic ec, input logic er);
        check({name, ".v"},     64'(v),           64'(ev));
        check({name, ".instr"}, 64'(instr),       64'(ei));
        check({name, ".pc"},    64'(pc),          64'(ep));
        check({name, ".comp"},  64'(compressed),  64'(ec));
        check({name, ".ready"}, 64'(fetch_ready), 64'(er));
    endtask

    // Drive at the falling edge, sample 1 time unit later (outputs reflect pre-edge state).
    task automatic run_vec(input vec_t t);
        @(negedge clk);
        fetch_v     = t.fv;
        fetch_pc    = t.fpc;
        fetch_instr = t.fw;
        yumi        = t.y;
        flush       = t.fl;
        #1;
        check_outs(t.name, t.ev, t.ei, t.ep, t.ec, t.er);
    endtask

    task automatic idle_then(input string name, input logic ev, input logic [31:0] ei,
                             input logic [VW-1:0] ep, input logic ec, input logic er,
                             input logic y);
        run_vec(mk(name, 1'b0, '0, '0, y, 1'b0, ev, ei, ep, ec, er));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; flush = 1'b0; fetch_v = 1'b0; fetch_pc = '0; fetch_instr = '0;
        yumi = 1'b0;

        // Aligned 32-bit
        vecs.push_back(mk("t1_acc",  1, PC0, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t1_out",  0, 0, 0, 1, 0, 1, 32'h0050_0093, PC0, 0, 0));
        vecs.push_back(mk("t1_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Two compressed
        vecs.push_back(mk("t2_acc",  1, PC0, 32'h4505_4501, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t2_lo",   0, 0, 0, 1, 0, 1, 32'h0000_4501, PC0, 1, 0));
        vecs.push_back(mk("t2_hi",   0, 0, 0, 1, 0, 1, 32'h0000_4505, PC0 + 2, 1, 0));
        vecs.push_back(mk("t2_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Straddle
        vecs.push_back(mk("t3_acc1", 1, PC0, 32'h0093_4501, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t3_c0",   0, 0, 0, 1, 0, 1, 32'h0000_4501, PC0, 1, 0));
        vecs.push_back(mk("t3_park", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t3_acc2", 1, PC0 + 4, 32'h4501_0050, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t3_strd", 0, 0, 0, 1, 0, 1, 32'h0050_0093, PC0 + 2, 0, 0));
        vecs.push_back(mk("t3_c1",   0, 0, 0, 1, 0, 1, 32'h0000_4501, PC0 + 6, 1, 0));
        vecs.push_back(mk("t3_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Misaligned entry
        vecs.push_back(mk("t4_acc",  1, PC0 + 2, 32'h4505_DEAD, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t4_out",  0, 0, 0, 1, 0, 1, 32'h0000_4505, PC0 + 2, 1, 0));
        vecs.push_back(mk("t4_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Flush in PARTIAL with a word offered
        vecs.push_back(mk("f1_acc",  1, PC0, 32'h0093_4501, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f1_c0",   0, 0, 0, 1, 0, 1, 32'h0000_4501, PC0, 1, 0));
        vecs.push_back(mk("f1_park", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("f1_flsh", 1, PC0 + 4, 32'h4501_0050, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f1_empt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f1_stay", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Flush coincident with an accept in EMPTY, then a normal aligned word
        vecs.push_back(mk("f2_flsh", 1, PC0, 32'h0050_0093, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f2_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f2_acc",  1, PC0, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f2_out",  0, 0, 0, 1, 0, 1, 32'h0050_0093, PC0, 0, 0));
        vecs.push_back(mk("f2_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Flush wins over yumi in WORD
        vecs.push_back(mk("f3_acc",  1, PC0, 32'h4505_4501, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("f3_flsh", 0, 0, 0, 1, 1, 1, 32'h0000_4501, PC0, 1, 0));
        vecs.push_back(mk("f3_empt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Reset state
        @(negedge clk);
        #1;
        check_outs("rst_hold", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("rst_rel", 0, 0, 0, 0, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure in WORD: 10 cycles without yumi
        run_vec(mk("bp_acc1", 1, PC0, 32'h0093_4501, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 10; k++) idle_then("bp_word", 1, 32'h0000_4501, PC0, 1, 0, 0);
        idle_then("bp_wtake", 1, 32'h0000_4501, PC0, 1, 0, 1);
        idle_then("bp_park", 0, 0, 0, 0, 0, 0);
        run_vec(mk("bp_acc2", 1, PC0 + 4, 32'h4501_0050, 0, 0, 0, 0, 0, 0, 1));
        // Backpressure in STRADDLE; new words offered must not be taken
        for (int k = 0; k < 10; k++) begin
            run_vec(mk("bp_strd", 1, PC0 + 8, 32'hFFFF_FFFF, 0, 0,
                       1, 32'h0050_0093, PC0 + 2, 0, 0));
        end

        // Asynchronous reset in the middle of a STRADDLE cycle
        fetch_v = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst_mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("rst_post", 0, 0, 0, 0, 1);
        run_vec(mk("pr_acc", 1, PC0, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 1));
        run_vec(mk("pr_out", 0, 0, 0, 1, 0, 1, 32'h0050_0093, PC0, 0, 0));
        run_vec(mk("pr_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
